// File: rtl/pe_feed_ctrl.sv
// PE array feed sequencer: per tile it clears the PEs, streams K weight/vector reads, flushes, then hands the result to the output writer.
// Optional fetch-stall support is compiled in with `define PE_FEED_STALL_EN.
module pe_feed_ctrl #(
    parameter int ARRAY_SIZE    = 32,
    parameter int OUTCOME_WIDTH = 32,
    parameter int K_ACCUM_DEPTH = 64,
    parameter int ADDR_W        = 10,
    parameter int TILE_W        = 8,
    parameter int PIPE_LAT      = 2
) (
    input  logic                                clk,
    input  logic                                srstn,
    input  logic                                start,
    input  logic [TILE_W-1:0]                   num_tiles,
    input  logic [ADDR_W-1:0]                   base_w,
    input  logic [ADDR_W-1:0]                   base_v,
    input  logic [ADDR_W-1:0]                   base_o,
    output logic                                busy,
    output logic                                done,
    output logic                                sram_ren,
    output logic [ADDR_W-1:0]                   sram_raddr_w,
    output logic [ADDR_W-1:0]                   sram_raddr_v,
    output logic                                alu_start,
    output logic [8:0]                          cycle_num,
    output logic                                pe_srstn,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ADDR_W-1:0]                   out_addr,
    output logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] out_data,
    input  logic                                in_stall
);

    localparam int DW = ARRAY_SIZE * OUTCOME_WIDTH;
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [8:0]    K_LAST = 9'(K_ACCUM_DEPTH - 1);
    localparam logic [FW-1:0] F_LAST = FW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_FLUSH,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [ADDR_W-1:0] bv_q, bv_d;
    logic [ADDR_W-1:0] bo_q, bo_d;
    logic [TILE_W-1:0] t_q, t_d;
    logic [TILE_W:0]   t_inc;
    logic [8:0]        k_q, k_d;
    logic [FW-1:0]     fl_q, fl_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic              alu_q, alu_d;
    logic [8:0]        cnum_q, cnum_d;
    logic              pe_q, pe_d;
    logic [DW-1:0]     odata_q, odata_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic              fetch_act;

`ifdef PE_FEED_STALL_EN
    assign fetch_act = (state_q == S_FETCH) && !in_stall;
`else
    logic unused_stall;
    assign unused_stall = in_stall;
    assign fetch_act    = (state_q == S_FETCH);
`endif

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            tiles_q <= '0;
            bv_q    <= '0;
            bo_q    <= '0;
            t_q     <= '0;
            k_q     <= '0;
            fl_q    <= '0;
            waddr_q <= '0;
            vaddr_q <= '0;
            alu_q   <= 1'b0;
            cnum_q  <= '0;
            pe_q    <= 1'b0;
            odata_q <= '0;
            oaddr_q <= '0;
        end else begin
            tiles_q <= tiles_d;
            bv_q    <= bv_d;
            bo_q    <= bo_d;
            t_q     <= t_d;
            k_q     <= k_d;
            fl_q    <= fl_d;
            waddr_q <= waddr_d;
            vaddr_q <= vaddr_d;
            alu_q   <= alu_d;
            cnum_q  <= cnum_d;
            pe_q    <= pe_d;
            odata_q <= odata_d;
            oaddr_q <= oaddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tiles_d = tiles_q;
        bv_d    = bv_q;
        bo_d    = bo_q;
        t_d     = t_q;
        k_d     = k_q;
        fl_d    = fl_q;
        waddr_d = waddr_q;
        vaddr_d = vaddr_q;
        odata_d = odata_q;
        oaddr_d = oaddr_q;
        t_inc   = {1'b0, t_q} + (TILE_W + 1)'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tiles_d = num_tiles;
                    bv_d    = base_v;
                    bo_d    = base_o;
                    waddr_d = base_w;
                    t_d     = '0;
                    k_d     = '0;
                    state_d = (num_tiles == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                vaddr_d = bv_q;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Tiles are weight-contiguous, so the weight address just keeps counting across tiles.
                if (fetch_act) begin
                    waddr_d = waddr_q + ADDR_W'(1);
                    vaddr_d = vaddr_q + ADDR_W'(1);
                    k_d     = k_q + 9'd1;
                    if (k_q == K_LAST) begin
                        fl_d    = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                fl_d = fl_q + FW'(1);
                if (fl_q == F_LAST) begin
                    odata_d = mul_outcome;
                    oaddr_d = bo_q + ADDR_W'(t_q);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (out_ready) begin
                    t_d     = t_inc[TILE_W-1:0];
                    state_d = (t_inc < {1'b0, tiles_q}) ? S_CLEAR : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        alu_d  = fetch_act;
        cnum_d = k_q;
        pe_d   = (state_d != S_CLEAR);
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign sram_ren     = fetch_act;
    assign sram_raddr_w = waddr_q;
    assign sram_raddr_v = vaddr_q;
    assign alu_start    = alu_q;
    assign cycle_num    = cnum_q;
    assign pe_srstn     = pe_q;
    assign out_valid    = (state_q == S_WRITE);
    assign out_addr     = oaddr_q;
    assign out_data     = odata_q;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Randomized bench for pe_feed_ctrl: an event-level scoreboard predicts read addresses, strobes, clears, results and done timing.
module tb_pe_feed_ctrl;

    localparam int K  = 4;
    localparam int PL = 2;
    localparam int AW = 10;
    localparam int TW = 8;
    localparam int AS = 2;
    localparam int OW = 16;
    localparam int DW = AS * OW;
`ifdef PE_FEED_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srstn;
    logic          start;
    logic [TW-1:0] num_tiles;
    logic [AW-1:0] base_w, base_v, base_o;
    logic          busy, done, sram_ren, alu_start, pe_srstn, out_valid;
    logic [AW-1:0] sram_raddr_w, sram_raddr_v, out_addr;
    logic [8:0]    cycle_num;
    logic [DW-1:0] mul_outcome, out_data;
    logic          out_ready;
    logic          in_stall;

    pe_feed_ctrl #(
        .ARRAY_SIZE(AS), .OUTCOME_WIDTH(OW), .K_ACCUM_DEPTH(K),
        .ADDR_W(AW), .TILE_W(TW), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .srstn(srstn), .start(start), .num_tiles(num_tiles),
        .base_w(base_w), .base_v(base_v), .base_o(base_o),
        .busy(busy), .done(done), .sram_ren(sram_ren),
        .sram_raddr_w(sram_raddr_w), .sram_raddr_v(sram_raddr_v),
        .alu_start(alu_start), .cycle_num(cycle_num), .pe_srstn(pe_srstn),
        .mul_outcome(mul_outcome), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .in_stall(in_stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit ready_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running input noise: fresh accumulator data every cycle, sporadic stalls, optional random ready.
    always @(posedge clk) begin
        #1;
        mul_outcome = DW'($urandom);
        in_stall    = ($urandom_range(3) == 0);
        if (ready_rand) out_ready = $urandom_range(1);
    end

    typedef struct {
        logic [AW-1:0] w;
        logic [AW-1:0] v;
        int            k;
    } rd_t;

    rd_t           rdq[$];
    logic [AW-1:0] wrq[$];
    bit            active, prev_ren, prev_pe, prev_stall, first_cyc;
    int            prev_k, pe_due, done_due, cap_at, valid_from;
    logic [DW-1:0] cap_val;

    always @(negedge clk) begin
        if (!srstn) begin
            rdq.delete();
            wrq.delete();
            active = 0; prev_ren = 0; prev_pe = 0; prev_stall = 0; prev_k = 0;
            pe_due = -1; done_due = -1; cap_at = -1; valid_from = -1;
            first_cyc = 1;
        end else begin
            bit   exp_valid;
            int   cur_k;
            rd_t  e;
            cur_k = 0;

            if (prev_ren) begin
                check("alu_start", alu_start, 1);
                check("cycle_num", cycle_num, prev_k);
            end else begin
                check("alu_idle", alu_start, 0);
            end

            if (sram_ren) begin
                if (rdq.size() == 0) begin
                    check("ren_spurious", 1, 0);
                end else begin
                    e = rdq.pop_front();
                    cur_k = e.k;
                    check("raddr_w", sram_raddr_w, e.w);
                    check("raddr_v", sram_raddr_v, e.v);
                    if (e.k == 0)
                        check("clear_before_fetch", (!prev_pe) || (STALL_EN && prev_stall), 1);
                    else if (!prev_ren)
                        check("fetch_gap", STALL_EN && prev_stall, 1);
                    if (e.k == K - 1) cap_at = cyc + PL;
                end
            end
            if (STALL_EN && in_stall) check("ren_in_stall", sram_ren, 0);

            if (cyc == cap_at) begin
                cap_val    = mul_outcome;
                valid_from = cyc + 1;
            end

            exp_valid = (valid_from >= 0) && (cyc >= valid_from);
            check("out_valid", out_valid, exp_valid);
            if (exp_valid && out_valid) begin
                if (wrq.size() == 0) begin
                    check("wr_queue", 0, 1);
                end else begin
                    check("out_addr", out_addr, wrq[0]);
                    check("out_data", out_data, cap_val);
                    if (out_ready) begin
                        void'(wrq.pop_front());
                        valid_from = -1;
                        if (wrq.size() == 0) done_due = cyc + 1;
                        else                 pe_due   = cyc + 1;
                    end
                end
            end

            check("pe_srstn", pe_srstn, (cyc != pe_due) && !first_cyc);
            check("done", done, cyc == done_due);
            check("busy", busy, active);

            if (active && cyc == done_due) begin
                active = 0;
                check("reads_left", rdq.size(), 0);
                check("writes_left", wrq.size(), 0);
            end else if (start && !active) begin
                active = 1;
                for (int t = 0; t < int'(num_tiles); t++) begin
                    for (int k = 0; k < K; k++) begin
                        e.w = base_w + AW'(t * K + k);
                        e.v = base_v + AW'(k);
                        e.k = k;
                        rdq.push_back(e);
                    end
                    wrq.push_back(base_o + AW'(t));
                end
                if (num_tiles == 0) done_due = cyc + 1;
                else                pe_due   = cyc + 1;
            end

            prev_ren   = sram_ren;
            prev_k     = cur_k;
            prev_pe    = pe_srstn;
            prev_stall = in_stall;
            first_cyc  = 0;
        end
    end

    task automatic pulse_start(input int tiles, input int bw, input int bv, input int bo);
        @(posedge clk);
        #2;
        start     = 1'b1;
        num_tiles = TW'(tiles);
        base_w    = AW'(bw);
        base_v    = AW'(bv);
        base_o    = AW'(bo);
        @(posedge clk);
        #2;
        start     = 1'b0;
        num_tiles = TW'($urandom);
        base_w    = AW'($urandom);
        base_v    = AW'($urandom);
        base_o    = AW'($urandom);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (!active) break;
        end
        if (i == 3000) check("job_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_job(input int tiles, input int bw, input int bv, input int bo);
        pulse_start(tiles, bw, bv, bo);
        wait_idle();
    endtask

    initial begin
        int i;
        srstn = 1'b0; start = 1'b0; num_tiles = '0;
        base_w = '0; base_v = '0; base_o = '0;
        out_ready = 1'b1; in_stall = 1'b0; mul_outcome = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", sram_ren, 0);
        check("rst_pe_srstn", pe_srstn, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 srstn = 1'b1;

        run_job(1, 'h10, 'h20, 'h30);

        // Two tiles with write back-pressure held for 5 cycles in tile 0.
        out_ready = 1'b0;
        pulse_start(2, 0, 'h20, 'h30);
        for (i = 0; i < 200 && !out_valid; i++) @(posedge clk);
        if (i == 200) check("valid_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
        wait_idle();

        run_job(0, 'h55, 'h66, 'h77);

        // A second start while busy must be ignored.
        pulse_start(2, 'h40, 'h50, 'h60);
        repeat (6) @(posedge clk);
        pulse_start(3, 'h100, 'h110, 'h120);
        wait_idle();

        // Reset in the middle of fetch aborts the job without a done pulse.
        pulse_start(2, 'h80, 'h90, 'ha0);
        for (i = 0; i < 50 && !sram_ren; i++) @(posedge clk);
        @(posedge clk);
        #1 srstn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ren", sram_ren, 0);
        check("abort_raddr_w", sram_raddr_w, 0);
        check("abort_alu", alu_start, 0);
        check("abort_pe_srstn", pe_srstn, 0);
        check("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1 srstn = 1'b1;
        repeat (3) @(posedge clk);
        run_job(1, 'h200, 'h210, 'h220);

        // Address wrap at the top of the SRAM.
        run_job(2, 'h3fe, 'h3fd, 'h3ff);

        ready_rand = 1'b1;
        for (int j = 0; j < 12; j++)
            run_job($urandom_range(3), $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_feed_ctrl.md
Name: pe_feed_ctrl

Overview:
- Sequencer that drives the PE array from the initiator side.
- Issues weight-column and vector-element SRAM reads and generates the aligned alu_start/cycle_num strobes the PE array consumes.
- After each tile it clears the PE accumulators, captures the wide accumulator result and hands it to the output-SRAM writer over a valid/ready handshake.
- Sits between the top-level command interface and PE_core / the SRAM macros.

Parameters:
- ARRAY_SIZE, 32, PE lanes per tile.
- OUTCOME_WIDTH, 32, bits per PE result.
- K_ACCUM_DEPTH, 64, reads (accumulation steps) per tile; legal range 1..512.
- ADDR_W, 10, SRAM address width.
- TILE_W, 8, width of the tile count.
- PIPE_LAT, 2, flush cycles after the last alu_start before the result is captured; must be at least 1.

Ports:
- clk  in  1  clock
- srstn  in  1  async active-low reset
- start  in  1  one-cycle command pulse
- num_tiles  in  TILE_W  tiles to run
- base_w  in  ADDR_W  weight SRAM base address
- base_v  in  ADDR_W  vector SRAM base address
- base_o  in  ADDR_W  output SRAM base address
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle completion pulse
- sram_ren  out  1  read enable, shared by the weight and vector SRAMs
- sram_raddr_w  out  ADDR_W  weight read address
- sram_raddr_v  out  ADDR_W  vector read address
- alu_start  out  1  PE data-valid strobe
- cycle_num  out  9  PE accumulation index
- pe_srstn  out  1  synchronous active-low PE clear
- mul_outcome  in  ARRAY_SIZE*OUTCOME_WIDTH  PE accumulator bus
- out_valid  out  1  result valid
- out_ready  in  1  writer accepts the result
- out_addr  out  ADDR_W  output SRAM address
- out_data  out  ARRAY_SIZE*OUTCOME_WIDTH  registered result
- in_stall  in  1  fetch stall (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. srstn is asynchronous and active-low. While srstn is low, all state returns to IDLE and every output is 0, except pe_srstn, which is 0 (PE held clear).
- Reset mid-operation aborts the current job. No done pulse is produced.
- Command capture: start is accepted only in IDLE and is ignored otherwise. On acceptance, num_tiles and all three base addresses are latched; the tile counter t and the step counter k are set to 0.
- State IDLE: if start is accepted with num_tiles==0, go to DONE. If start is accepted with num_tiles>0, go to CLEAR.
- State CLEAR (1 cycle): pe_srstn=0, then go to FETCH. pe_srstn is 1 in every other state after reset.
- State FETCH (K_ACCUM_DEPTH active cycles):
  - sram_ren=1.
  - sram_raddr_w = base_w + t*K_ACCUM_DEPTH + k, truncated to ADDR_W (wraps silently).
  - sram_raddr_v = base_v + k, truncated to ADDR_W.
  - k increments each active cycle. After k = K_ACCUM_DEPTH-1, go to FLUSH.
- SRAM read latency is 1 cycle. alu_start is sram_ren delayed 1 cycle. cycle_num is k delayed 1 cycle, zero-extended to 9 bits.
- State FLUSH: lasts PIPE_LAT cycles; a counter is used. On the last FLUSH cycle, out_data <= mul_outcome, out_addr <= base_o + t, and the block goes to WRITE.
- State WRITE:
  - out_valid=1.
  - out_data and out_addr are held stable until out_valid && out_ready.
  - On that handshake, out_valid drops next cycle and t increments.
  - If t+1 < num_tiles, go to CLEAR (k=0). Otherwise go to DONE.
  - If out_ready is already high on the first WRITE cycle, the result is accepted in that cycle.
- State DONE (1 cycle): done=1, then go to IDLE. busy is 0 in the same cycle done falls.
- Output values: out_valid, alu_start and done are never asserted in any state other than those listed above.

Optional Feature:
- Macro: PE_FEED_STALL_EN.
- Defined: in FETCH, in_stall=1 makes the cycle inactive. sram_ren=0, k holds and the addresses hold. alu_start follows sram_ren, so a stalled read produces no alu_start one cycle later. in_stall is ignored in all other states.
- Undefined: in_stall is ignored entirely; FETCH always lasts exactly K_ACCUM_DEPTH cycles.

Test Plan (K_ACCUM_DEPTH=4, PIPE_LAT=2, ADDR_W=10):
- Single tile: start with num_tiles=1, base_w=0x10, base_v=0x20, base_o=0x30, out_ready=1.
  - Expect: pe_srstn low 1 cycle. sram_raddr_w 0x10..0x13 and sram_raddr_v 0x20..0x23 on 4 consecutive sram_ren cycles. alu_start high 4 cycles, one cycle later, with cycle_num 0..3.
  - Expect: out_valid with out_addr=0x30 and out_data = the mul_outcome value from the last FLUSH cycle. done 1 cycle later.
- Two tiles with base_w=0, out_ready held low 5 cycles in tile 0:
  - out_valid stays high and out_data stays stable through the hold.
  - Second tile fetches weights 4..7. out_addr is 0x30 then 0x31.
  - Exactly one done pulse.
- num_tiles=0: done one cycle after start, with no sram_ren, pe_srstn or out_valid activity.
- start pulsed while busy: ignored. Address sequence and tile count are unchanged.
- srstn asserted mid-FETCH: all outputs 0 and pe_srstn 0 immediately; block is IDLE after release; no done pulse. A following start runs normally.
- With PE_FEED_STALL_EN defined: in_stall high during fetch step 2 for 3 cycles → sram_ren low and address held at offset 2 for those 3 cycles. alu_start has a matching 3-cycle gap. cycle_num sequence is still 0..3.
